// File: rtl/spi_regfile_pkg.sv
// Shared types and frame-geometry helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Total frame length: R/W bit + address field + data field
  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Position of the R/W bit within the fully shifted frame
  function automatic int unsigned rw_bit(input int unsigned addr_w, input int unsigned data_w);
    return frame_w(addr_w, data_w) - 1;
  endfunction

  // LSB of the address field within the fully shifted frame
  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  // Bit counter width; must hold the saturation value FRAME_W+1
  function automatic int unsigned cnt_w(input int unsigned addr_w, input int unsigned data_w);
    return $clog2(frame_w(addr_w, data_w) + 2);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin plus rise/fall detection.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q      = sync[SYNC_STAGES-1];
  assign rise_c = q & ~prev;
  assign fall_c = ~q & prev;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral driving a bank of control registers.
// Build option SPI_READBACK_EN: when defined, read frames return reg[addr] on CIPO;
// when undefined, CIPO/CIPO_oe are tied low and correct-length reads are ignored.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         nCS,
  input  logic                         SCLK,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int unsigned FRAME_W  = frame_w(ADDR_W, DATA_W);
  localparam int unsigned RW_BIT   = rw_bit(ADDR_W, DATA_W);
  localparam int unsigned ADDR_LSB = addr_lsb(DATA_W);
  localparam int unsigned CNT_W    = cnt_w(ADDR_W, DATA_W);
  localparam int unsigned CMD_W    = 1 + ADDR_W;

  logic cs_q, cs_rise, cs_fall_unused;
  logic sclk_q_unused, sclk_rise_raw, sclk_fall_raw;
  logic sclk_rise;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic copi_q;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] shreg;
  logic [ADDR_W-1:0]  addr_field;
  logic [DATA_W-1:0]  data_field;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (nCS),
    .q      (cs_q),
    .rise_c (cs_rise),
    .fall_c (cs_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (SCLK),
    .q      (sclk_q_unused),
    .rise_c (sclk_rise_raw),
    .fall_c (sclk_fall_raw)
  );

  // COPI uses the same depth as SCLK so a detected edge sees the matching data bit
  always_ff @(posedge clk) begin
    if (!rst_n) copi_sync <= '0;
    else        copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
  end

  assign copi_q     = copi_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_rise_raw & ~cs_q;
  assign addr_field = shreg[ADDR_LSB +: ADDR_W];
  assign data_field = shreg[DATA_W-1:0];

  // Frame FSM: shift COPI in, check length and commit writes when nCS rises
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      regs_flat <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      if (cs_rise) begin
        if (state == IDLE) begin
          state <= IDLE;
        end else begin
          state <= COMMIT;
          if (cnt == CNT_W'(FRAME_W)) begin
            if (shreg[RW_BIT] == RW_WRITE) begin
              for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (addr_field == ADDR_W'(i)) begin
                  regs_flat[i*DATA_W +: DATA_W] <= data_field;
                  wr_strobe[i]                  <= 1'b1;
                end
              end
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            // Level test also catches an nCS fall that landed during COMMIT
            if (!cs_q) begin
              state <= CMD;
              cnt   <= '0;
              shreg <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shreg <= {shreg[FRAME_W-2:0], copi_q};
              cnt   <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(CMD_W - 1)) state <= DATA;
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shreg <= {shreg[FRAME_W-2:0], copi_q};
              if (cnt != CNT_W'(FRAME_W + 1)) cnt <= cnt + CNT_W'(1);
            end
          end
          COMMIT:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] rd_sel;
  logic [DATA_W-1:0] rdbk;
  logic              rd_loaded;
  logic              cipo_q;
  logic              cipo_oe_q;

  assign sclk_fall = sclk_fall_raw & ~cs_q;

  // Readback source: addressed register for a valid read, zero otherwise
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (shreg[ADDR_W] == RW_READ && shreg[ADDR_W-1:0] == ADDR_W'(i)) begin
        rd_sel = regs_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // Readback shifter: load on first data-phase SCLK fall, then shift MSB-first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdbk      <= '0;
      rd_loaded <= 1'b0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
    end else begin
      cipo_oe_q <= ~cs_q;
      if (cs_q || state != DATA) begin
        rdbk      <= '0;
        rd_loaded <= 1'b0;
        cipo_q    <= 1'b0;
      end else if (sclk_fall) begin
        if (!rd_loaded) begin
          rdbk      <= rd_sel;
          rd_loaded <= 1'b1;
          cipo_q    <= rd_sel[DATA_W-1];
        end else begin
          rdbk   <= {rdbk[DATA_W-2:0], 1'b0};
          cipo_q <= rdbk[DATA_W-2];
        end
      end
    end
  end

  assign CIPO    = cipo_q;
  assign CIPO_oe = cipo_oe_q;
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall_raw;
  assign CIPO    = 1'b0;
  assign CIPO_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench for spi_regfile_peripheral: table of frames plus reset and back-to-back sequences.
module tb_spi_regfile_peripheral;

  localparam int unsigned NUM_REGS    = 5;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FRAME_W     = 1 + ADDR_W + DATA_W;
  localparam int unsigned CMD_W       = 1 + ADDR_W;
  localparam int          HALF        = 4;
  localparam int          GAP_DEF     = SYNC_STAGES + 4;
  localparam int          GAP_MIN     = SYNC_STAGES + 2;
`ifdef SPI_READBACK_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0]         bits;
    int                  nbits;
    logic                is_read;
    logic [NUM_REGS-1:0] exp_strobe;
    logic                exp_err;
    logic [DATA_W-1:0]   exp_rd;
  } vec_t;

  typedef struct {
    logic [NUM_REGS-1:0]        strobe;
    logic                       err;
    logic [NUM_REGS*DATA_W-1:0] regs;
    int                         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n, nCS, SCLK, COPI;
  logic CIPO, CIPO_oe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [NUM_REGS-1:0]        wr_strobe;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  ev_t exp_q[$];
  logic [NUM_REGS*DATA_W-1:0] shadow = '0;
  vec_t vt[10];

  spi_regfile_peripheral #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nCS       (nCS),
    .SCLK      (SCLK),
    .COPI      (COPI),
    .CIPO      (CIPO),
    .CIPO_oe   (CIPO_oe),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    return {16'h0, rw, addr, data};
  endfunction

  // Scoreboard consumer: every strobe or error pulse must match the oldest expectation
  always @(negedge clk) begin
    ev_t e;
    if (wr_strobe != '0 || frame_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 64'({wr_strobe, frame_err}), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_strobe", 64'(wr_strobe), 64'(e.strobe));
        check("frame_err", 64'(frame_err), 64'(e.err));
        check("regs_at_event", 64'(regs_flat), 64'(e.regs));
        check("event_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Clock out nbits of a frame MSB-first, capturing CIPO at each data-phase SCLK rise
  task automatic shift_bits(input logic [31:0] bits, input int nbits, output logic [DATA_W-1:0] rd);
    rd = '0;
    for (int p = 0; p < nbits; p++) begin
      COPI = bits[nbits-1-p];
      tick(HALF);
      SCLK = 1'b1;
      if (p == 0) check("cipo_oe_in_frame", 64'(CIPO_oe), 64'(RB_EN));
      if (p >= int'(CMD_W) && p < int'(FRAME_W)) rd = {rd[DATA_W-2:0], CIPO};
      tick(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input vec_t v, input int gap);
    logic [DATA_W-1:0] rd;
    ev_t e;
    nCS = 1'b0;
    tick(HALF);
    shift_bits(v.bits, v.nbits, rd);
    tick(HALF);
    if (v.exp_strobe != '0 || v.exp_err) begin
      for (int i = 0; i < int'(NUM_REGS); i++)
        if (v.exp_strobe[i]) shadow[i*DATA_W +: DATA_W] = v.bits[DATA_W-1:0];
      e.strobe = v.exp_strobe;
      e.err    = v.exp_err;
      e.regs   = shadow;
      e.cyc    = cyc + SYNC_STAGES + 1;
      exp_q.push_back(e);
    end
    nCS = 1'b1;
    tick(gap);
    check("cipo_oe_after", 64'(CIPO_oe), 64'(0));
    check("cipo_after", 64'(CIPO), 64'(0));
    check("pending_events", 64'(exp_q.size()), 64'(0));
    if (v.is_read) check("readback", 64'(rd), RB_EN ? 64'(v.exp_rd) : 64'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] rd_dummy;
    vec_t v;

    // {bits, nbits, is_read, exp_strobe, exp_err, exp_rd}
    vt[0] = '{mk(1'b1, 7'd0,   8'hA5), 16, 1'b0, 5'b00001, 1'b0, 8'h00};
    vt[1] = '{mk(1'b1, 7'd4,   8'h80), 16, 1'b0, 5'b10000, 1'b0, 8'h00};
    vt[2] = '{mk(1'b0, 7'd4,   8'h00), 16, 1'b1, 5'b00000, 1'b0, 8'h80};
    vt[3] = '{mk(1'b1, 7'd5,   8'hFF), 16, 1'b0, 5'b00000, 1'b0, 8'h00};
    vt[4] = '{mk(1'b0, 7'd5,   8'h00), 16, 1'b1, 5'b00000, 1'b0, 8'h00};
    // 10-bit frame {1, addr 1, 2'b10}
    vt[5] = '{32'h0000_0206,           10, 1'b0, 5'b00000, 1'b1, 8'h00};
    // 18-bit frame {1, addr 1, 8'h77, 2'b11}
    vt[6] = '{32'h0002_05DF,           18, 1'b0, 5'b00000, 1'b1, 8'h00};
    vt[7] = '{mk(1'b0, 7'd0,   8'h00), 16, 1'b1, 5'b00000, 1'b0, 8'hA5};
    vt[8] = '{mk(1'b1, 7'd127, 8'h5A), 16, 1'b0, 5'b00000, 1'b0, 8'h00};
    vt[9] = '{mk(1'b0, 7'd1,   8'h00), 16, 1'b1, 5'b00000, 1'b0, 8'h00};

    rst_n = 1'b0;
    nCS   = 1'b1;
    SCLK  = 1'b0;
    COPI  = 1'b0;
    tick(3);
    check("rst_regs", 64'(regs_flat), 64'(0));
    check("rst_strobe", 64'(wr_strobe), 64'(0));
    check("rst_err", 64'(frame_err), 64'(0));
    check("rst_cipo", 64'(CIPO), 64'(0));
    check("rst_cipo_oe", 64'(CIPO_oe), 64'(0));
    rst_n = 1'b1;
    tick(4);

    for (int k = 0; k < 10; k++) run_frame(vt[k], GAP_DEF);
    check("regs_after_table", 64'(regs_flat), 64'(shadow));

    // Reset after 9 bits of a write to addr 2: frame abandoned, bank cleared
    nCS = 1'b0;
    tick(HALF);
    shift_bits(mk(1'b1, 7'd2, 8'hFF), 9, rd_dummy);
    tick(HALF);
    rst_n = 1'b0;
    nCS   = 1'b1;
    tick(1);
    rst_n  = 1'b1;
    shadow = '0;
    check("midrst_regs", 64'(regs_flat), 64'(0));
    check("midrst_strobe", 64'(wr_strobe), 64'(0));
    check("midrst_err", 64'(frame_err), 64'(0));
    check("midrst_cipo", 64'(CIPO), 64'(0));
    check("midrst_cipo_oe", 64'(CIPO_oe), 64'(0));
    tick(GAP_DEF);

    v = '{mk(1'b1, 7'd2, 8'h3C), 16, 1'b0, 5'b00100, 1'b0, 8'h00};
    run_frame(v, GAP_DEF);

    // Back-to-back writes to addr 3 with minimum nCS-high gap
    v = '{mk(1'b1, 7'd3, 8'h11), 16, 1'b0, 5'b01000, 1'b0, 8'h00};
    run_frame(v, GAP_MIN);
    v = '{mk(1'b1, 7'd3, 8'h22), 16, 1'b0, 5'b01000, 1'b0, 8'h00};
    run_frame(v, GAP_DEF);
    check("regs_final", 64'(regs_flat), 64'(shadow));

    tick(4);
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
